// File: rtl/register_file_pkg.sv
// Shared types and helpers for the multi-port register file: FSM state
// encoding and the index-width calculation used for all index buses.
package register_file_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } rf_state_e;

    // Index width for a given register count; never narrower than one bit.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: storage lookup, optional write-to-read
// forwarding, and optional hardwired-zero register 0.
module rf_read_port
    import register_file_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int IDX_W    = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic [IDX_W-1:0]       index,
    input  logic [DEPTH*WIDTH-1:0] storage,
    input  logic                   bypass_valid,
    input  logic [IDX_W-1:0]       bypass_index,
    input  logic [WIDTH-1:0]       bypass_data,
    output logic [WIDTH-1:0]       data
);

    // Later assignments take priority: the zero register overrides forwarding.
    always_comb begin
        data = storage[int'(index)*WIDTH +: WIDTH];
        if (BYPASS != 0 && bypass_valid && bypass_index == index) begin
            data = bypass_data;
        end
        if (ZERO_REG != 0 && index == '0) begin
            data = '0;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with a valid/ready write port,
// optional bypass, optional zero register and a sequenced clear sweep.
module register_file_mp
    import register_file_pkg::*;
#(
    parameter int  WIDTH      = 16,
    parameter int  DEPTH      = 4,
    parameter int  READ_PORTS = 2,
    parameter int  BYPASS     = 1,
    parameter int  ZERO_REG   = 0,
    localparam int IDX_W      = idx_width(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [READ_PORTS*IDX_W-1:0] read_index,
    output logic [READ_PORTS*WIDTH-1:0] read_data,
    input  logic                        write_valid,
    output logic                        write_ready,
    input  logic [IDX_W-1:0]            write_index,
    input  logic [WIDTH-1:0]            write_data,
    input  logic                        clear_req,
    output logic                        busy
);

    rf_state_e        state;
    rf_state_e        state_next;
    logic [IDX_W-1:0] sweep_cnt;
    logic [IDX_W-1:0] sweep_cnt_next;
    logic             active;
    logic             write_fire;
    logic             write_keep;

    logic [WIDTH-1:0]       regs [DEPTH];
    logic [DEPTH*WIDTH-1:0] storage_flat;

    // Holds write_ready low until the first edge after reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active <= 1'b0;
        end else begin
            active <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sweep_cnt <= '0;
        end else begin
            state     <= state_next;
            sweep_cnt <= sweep_cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        state_next     = state;
        sweep_cnt_next = sweep_cnt;
        write_ready    = 1'b0;
        busy           = 1'b0;
        case (state)
            IDLE: begin
                write_ready = active;
                if (active && clear_req) begin
                    state_next     = CLEAR;
                    sweep_cnt_next = '0;
                end
            end
            CLEAR: begin
                busy           = 1'b1;
                sweep_cnt_next = sweep_cnt + 1'b1;
                if (sweep_cnt == IDX_W'(DEPTH - 1)) begin
                    state_next     = IDLE;
                    sweep_cnt_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign write_fire = write_valid && write_ready;
    // Writes to register 0 complete the handshake but are dropped when it is hardwired.
    assign write_keep = write_fire && !(ZERO_REG != 0 && write_index == '0);

    // NOTE: the storage array is reset because reads must return 0 after reset; this makes it flops, not a RAM macro.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[sweep_cnt] <= '0;
        end else if (write_keep) begin
            regs[write_index] <= write_data;
        end
    end

    for (genvar r = 0; r < DEPTH; r++) begin : g_flat
        assign storage_flat[r*WIDTH +: WIDTH] = regs[r];
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        rf_read_port #(
            .WIDTH    (WIDTH),
            .DEPTH    (DEPTH),
            .IDX_W    (IDX_W),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG)
        ) u_read_port (
            .index        (read_index[p*IDX_W +: IDX_W]),
            .storage      (storage_flat),
            .bypass_valid (write_fire),
            .bypass_index (write_index),
            .bypass_data  (write_data),
            .data         (read_data[p*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: three instances (default, no bypass,
// hardwired zero register) share one stimulus stream.
module tb_register_file_mp;

    logic        clk;
    logic        reset_n;
    logic [3:0]  read_index;
    logic        write_valid;
    logic [1:0]  write_index;
    logic [15:0] write_data;
    logic        clear_req;

    logic [31:0] rdata_a, rdata_b, rdata_c;
    logic        ready_a, ready_b, ready_c;
    logic        busy_a, busy_b, busy_c;

    int total;
    int passed;

    register_file_mp u_dut_a (
        .clk (clk), .reset_n (reset_n), .read_index (read_index), .read_data (rdata_a),
        .write_valid (write_valid), .write_ready (ready_a), .write_index (write_index),
        .write_data (write_data), .clear_req (clear_req), .busy (busy_a)
    );

    register_file_mp #(.BYPASS(0)) u_dut_b (
        .clk (clk), .reset_n (reset_n), .read_index (read_index), .read_data (rdata_b),
        .write_valid (write_valid), .write_ready (ready_b), .write_index (write_index),
        .write_data (write_data), .clear_req (clear_req), .busy (busy_b)
    );

    register_file_mp #(.ZERO_REG(1)) u_dut_c (
        .clk (clk), .reset_n (reset_n), .read_index (read_index), .read_data (rdata_c),
        .write_valid (write_valid), .write_ready (ready_c), .write_index (write_index),
        .write_data (write_data), .clear_req (clear_req), .busy (busy_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pd(input logic [31:0] bus, input int p);
        return {16'h0000, bus[p*16 +: 16]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [1:0] i0, input logic [1:0] i1);
        read_index = {i1, i0};
    endtask

    task automatic wr(input logic [1:0] idx, input logic [15:0] dat);
        write_valid = 1'b1;
        write_index = idx;
        write_data  = dat;
    endtask

    initial begin
        total       = 0;
        passed      = 0;
        reset_n     = 1'b0;
        read_index  = '0;
        write_valid = 1'b0;
        write_index = '0;
        write_data  = '0;
        clear_req   = 1'b0;

        // Reset state
        tick();
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_rdata_b", rdata_b, 32'd0);
        #1;
        reset_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(ready_a), 32'd0);
        tick();
        check("ready_after_edge", 32'(ready_a), 32'd1);
        check("busy_idle", 32'(busy_b), 32'd0);

        // Basic write r2 = 1234
        wr(2'd2, 16'h1234);
        set_rd(2'd2, 2'd3);
        #1;
        check("byp_a_r2", pd(rdata_a, 0), 32'h1234);
        check("nobyp_b_r2", pd(rdata_b, 0), 32'h0000);
        tick();
        write_valid = 1'b0;
        #1;
        check("a_r2", pd(rdata_a, 0), 32'h1234);
        check("a_r3", pd(rdata_a, 1), 32'h0000);
        check("b_r2", pd(rdata_b, 0), 32'h1234);

        // Bypass vs no bypass on r1
        wr(2'd1, 16'h1111);
        tick();
        wr(2'd1, 16'hBEEF);
        set_rd(2'd1, 2'd1);
        #1;
        check("byp_a_p0", pd(rdata_a, 0), 32'hBEEF);
        check("byp_a_p1", pd(rdata_a, 1), 32'hBEEF);
        check("nobyp_b_p0_old", pd(rdata_b, 0), 32'h1111);
        check("nobyp_b_p1_old", pd(rdata_b, 1), 32'h1111);
        tick();
        write_valid = 1'b0;
        #1;
        check("nobyp_b_p0_new", pd(rdata_b, 0), 32'hBEEF);
        check("nobyp_b_p1_new", pd(rdata_b, 1), 32'hBEEF);

        // Hardwired zero register
        wr(2'd0, 16'hFFFF);
        set_rd(2'd0, 2'd0);
        #1;
        check("zr_ready", 32'(ready_c), 32'd1);
        check("zr_byp_p0", pd(rdata_c, 0), 32'h0000);
        check("zr_byp_p1", pd(rdata_c, 1), 32'h0000);
        check("a_byp_r0", pd(rdata_a, 0), 32'hFFFF);
        tick();
        write_valid = 1'b0;
        #1;
        check("zr_p0", pd(rdata_c, 0), 32'h0000);
        check("zr_p1", pd(rdata_c, 1), 32'h0000);
        check("zr_ready_after", 32'(ready_c), 32'd1);
        check("b_r0", pd(rdata_b, 0), 32'hFFFF);

        // Fill and sweep, with a write held across the sweep
        for (int i = 0; i < 4; i++) begin
            wr(2'(i), 16'(16'h0A0A + i * 16'h0101));
            tick();
        end
        write_valid = 1'b0;
        set_rd(2'd0, 2'd3);
        clear_req = 1'b1;
        #1;
        check("pre_clear_busy", 32'(busy_a), 32'd0);
        tick();
        clear_req = 1'b0;
        wr(2'd1, 16'h7777);
        #1;
        check("sw0_busy", 32'(busy_a), 32'd1);
        check("sw0_ready", 32'(ready_a), 32'd0);
        check("sw0_r0", pd(rdata_a, 0), 32'h0A0A);
        check("sw0_r3", pd(rdata_a, 1), 32'h0D0D);
        tick();
        check("sw1_r0", pd(rdata_a, 0), 32'h0000);
        check("sw1_r3", pd(rdata_a, 1), 32'h0D0D);
        check("sw1_busy", 32'(busy_a), 32'd1);
        tick();
        check("sw2_busy", 32'(busy_a), 32'd1);
        tick();
        check("sw3_busy", 32'(busy_a), 32'd1);
        check("sw3_ready", 32'(ready_a), 32'd0);
        check("sw3_r3", pd(rdata_a, 1), 32'h0D0D);
        tick();
        set_rd(2'd1, 2'd3);
        #1;
        check("swend_busy", 32'(busy_a), 32'd0);
        check("swend_ready", 32'(ready_a), 32'd1);
        check("swend_a_byp_r1", pd(rdata_a, 0), 32'h7777);
        check("swend_b_r1", pd(rdata_b, 0), 32'h0000);
        check("swend_r3", pd(rdata_a, 1), 32'h0000);
        tick();
        write_valid = 1'b0;
        #1;
        check("held_write_b_r1", pd(rdata_b, 0), 32'h7777);

        // Same-edge write and clear
        wr(2'd3, 16'h5555);
        clear_req = 1'b1;
        set_rd(2'd3, 2'd3);
        tick();
        write_valid = 1'b0;
        clear_req   = 1'b0;
        #1;
        check("se_busy", 32'(busy_b), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("se_r3_sweep%0d", i), pd(rdata_b, 1), 32'h5555);
        end
        tick();
        check("se_r3_cleared", pd(rdata_b, 1), 32'h0000);
        check("se_busy_done", 32'(busy_b), 32'd0);

        // Reset mid-sweep at counter 2
        wr(2'd3, 16'h3333);
        tick();
        wr(2'd2, 16'h2222);
        tick();
        write_valid = 1'b0;
        clear_req   = 1'b1;
        set_rd(2'd3, 2'd2);
        tick();
        clear_req = 1'b0;
        tick();
        tick();
        check("mid_r3", pd(rdata_a, 0), 32'h3333);
        check("mid_r2", pd(rdata_a, 1), 32'h2222);
        check("mid_busy", 32'(busy_a), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mr_busy", 32'(busy_a), 32'd0);
        check("mr_ready", 32'(ready_a), 32'd0);
        check("mr_rdata_a", rdata_a, 32'd0);
        check("mr_rdata_b", rdata_b, 32'd0);
        #2;
        reset_n = 1'b1;
        #1;
        check("mr_ready_pre_edge", 32'(ready_a), 32'd0);
        tick();
        check("mr_ready_post_edge", 32'(ready_a), 32'd1);
        check("mr_busy_post", 32'(busy_a), 32'd0);
        check("mr_rdata_post", rdata_a, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
